// File: rtl/simmem_pkg.sv
// Shared types and constants for the simulated memory controller.
// Adds WReqQueueDepth, the default command queue depth of the write-request emitter.
package simmem_pkg;

    localparam int AddrWidth      = 32;
    localparam int IdWidth        = 4;
    localparam int AxLenWidth     = 5;
    localparam int MaxWBurstLen   = 16;
    localparam int MaxWBurstLenW  = $clog2(MaxWBurstLen);
    localparam int WReqQueueDepth = 8;

    // burst_len is a beat count; 0 means an address-only request
    typedef struct packed {
        logic [IdWidth-1:0]    id;
        logic [AddrWidth-1:0]  addr;
        logic [AxLenWidth-1:0] burst_len;
    } waddr_t;

endpackage

// File: rtl/simmem_wreq_queue.sv
// Command queue for the write-request emitter: circular buffer with one write pointer and
// independent address/data read pointers; an entry frees once both read pointers have passed it.
module simmem_wreq_queue
    import simmem_pkg::*;
#(
    parameter int Depth = WReqQueueDepth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  waddr_t                push_cmd,
    input  logic                  push,
    output logic                  ready,
    input  logic                  addr_hs,
    input  logic                  beat_hs,
    output waddr_t                addr_cmd,
    output logic                  addr_occ,
    output logic [AxLenWidth-1:0] addr_beats,
    output logic                  data_occ,
    output logic [AxLenWidth-1:0] data_len,
    output logic                  data_addr_done,
    output logic [AxLenWidth-1:0] data_beats,
    output logic                  data_last,
    output logic                  same_entry
);

    localparam int IdxW = $clog2(Depth);
    localparam int PtrW = IdxW + 1;

    logic [PtrW-1:0]       wpt, apt, dpt;
    logic [PtrW-1:0]       occ_a, occ_d, occ;
    logic [IdxW-1:0]       w_idx, a_idx, d_idx;
    waddr_t                cmd_q   [Depth];
    logic [AxLenWidth-1:0] beats_q [Depth];
    logic [Depth-1:0]      addr_done_q;
    logic                  data_zero;

    assign w_idx = wpt[IdxW-1:0];
    assign a_idx = apt[IdxW-1:0];
    assign d_idx = dpt[IdxW-1:0];

    // Whichever read pointer lags determines how many entries are still held.
    assign occ_a = wpt - apt;
    assign occ_d = wpt - dpt;
    assign occ   = (occ_a > occ_d) ? occ_a : occ_d;
    assign ready = (occ != PtrW'(Depth));

    assign addr_occ       = (apt != wpt);
    assign addr_cmd       = cmd_q[a_idx];
    assign addr_beats     = beats_q[a_idx];
    assign data_occ       = (dpt != wpt);
    assign data_len       = cmd_q[d_idx].burst_len;
    assign data_addr_done = addr_done_q[d_idx];
    assign data_beats     = beats_q[d_idx];
    assign data_last      = (data_beats == data_len - AxLenWidth'(1));
    assign data_zero      = data_occ && (data_len == '0);
    assign same_entry     = (apt == dpt);

    always_ff @(posedge clk) begin
        if (rst) begin
            wpt         <= '0;
            apt         <= '0;
            dpt         <= '0;
            addr_done_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                cmd_q[i]   <= '0;
                beats_q[i] <= '0;
            end
        end else begin
            if (push) begin
                cmd_q[w_idx]       <= push_cmd;
                addr_done_q[w_idx] <= 1'b0;
                beats_q[w_idx]     <= '0;
                wpt                <= wpt + PtrW'(1);
            end
            if (addr_hs) begin
                addr_done_q[a_idx] <= 1'b1;
                apt                <= apt + PtrW'(1);
            end
            // Zero-length entries carry no data, so the data pointer steps over them.
            if (beat_hs) begin
                beats_q[d_idx] <= data_beats + AxLenWidth'(1);
                if (data_last) dpt <= dpt + PtrW'(1);
            end else if (data_zero) begin
                dpt <= dpt + PtrW'(1);
            end
        end
    end

endmodule

// File: rtl/simmem_wreq_emitter.sv
// Write-request emitter: drives waddr/wdata with data allowed to lead addresses by a bounded count.
// Defining SIMMEM_WREQ_ADDR_FIRST_EN forces every beat to wait for its address and drops the lead counter.
module simmem_wreq_emitter
    import simmem_pkg::*;
#(
    parameter int Depth            = WReqQueueDepth,
    parameter int MaxDataLeadBeats = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  waddr_t                                cmd_i,
    input  logic                                  cmd_valid_i,
    output logic                                  cmd_ready_o,
    output waddr_t                                waddr_o,
    output logic                                  waddr_valid_o,
    input  logic                                  waddr_ready_i,
    output logic                                  wdata_valid_o,
    input  logic                                  wdata_ready_i,
    output logic                                  wdata_last_o,
    output logic [MaxWBurstLenW-1:0]              wdata_beat_idx_o,
    output logic [$clog2(MaxDataLeadBeats+1)-1:0] lead_cnt_o
);

    localparam int LeadW = $clog2(MaxDataLeadBeats + 1);

    logic                  addr_occ, data_occ, data_addr_done, data_last, same_entry;
    logic [AxLenWidth-1:0] addr_beats, data_len, data_beats;
    logic                  beat_ok, addr_hs, beat_hs;

    simmem_wreq_queue #(.Depth(Depth)) u_queue (
        .clk            (clk_i),
        .rst            (rst_i),
        .push_cmd       (cmd_i),
        .push           (cmd_valid_i && cmd_ready_o),
        .ready          (cmd_ready_o),
        .addr_hs        (addr_hs),
        .beat_hs        (beat_hs),
        .addr_cmd       (waddr_o),
        .addr_occ       (addr_occ),
        .addr_beats     (addr_beats),
        .data_occ       (data_occ),
        .data_len       (data_len),
        .data_addr_done (data_addr_done),
        .data_beats     (data_beats),
        .data_last      (data_last),
        .same_entry     (same_entry)
    );

`ifdef SIMMEM_WREQ_ADDR_FIRST_EN
    assign beat_ok    = data_addr_done;
    assign lead_cnt_o = '0;
`else
    localparam logic [LeadW-1:0] LeadMax = LeadW'(MaxDataLeadBeats);

    logic [LeadW-1:0] lead_q, lead_dec, lead_inc;

    assign beat_ok  = data_addr_done || (lead_q < LeadMax);
    assign lead_dec = addr_hs ? LeadW'(addr_beats) : '0;
    // A beat riding alongside its own address counts as following it.
    assign lead_inc = LeadW'(beat_hs && !data_addr_done && !(addr_hs && same_entry));

    always_ff @(posedge clk_i) begin
        if (rst_i) lead_q <= '0;
        else       lead_q <= lead_q - lead_dec + lead_inc;
    end

    assign lead_cnt_o = lead_q;
`endif

    assign waddr_valid_o    = addr_occ;
    assign wdata_valid_o    = data_occ && (data_len != '0) && beat_ok;
    assign wdata_last_o     = wdata_valid_o && data_last;
    assign wdata_beat_idx_o = wdata_valid_o ? data_beats[MaxWBurstLenW-1:0] : '0;
    assign addr_hs          = waddr_valid_o && waddr_ready_i;
    assign beat_hs          = wdata_valid_o && wdata_ready_i;

endmodule

// File: doc/simmem_wreq_emitter.md
# simmem_wreq_emitter

Requester-side write-request transmitter for the simulated memory controller. It accepts write commands from a traffic source and emits them on the write address and write data channels with an independently skewed data stream: data beats of a burst may lead their address by a bounded number of beats, or trail it. It is the driving end of the waddr/wdata interface that the delay calculator snoops. It serves as the stimulus engine in system benches and as a requester model in the simulated-memory top.

## Interface
- `Depth`, default 8: command queue entries; power of two, ≥ 2.
- `MaxDataLeadBeats`, default 16: maximum number of data beats issued ahead of their address handshakes; ≥ 1.
- Clock is `clk_i`. Reset is `rst_i`. The block uses one clock. Reset is synchronous and active-high.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `cmd_i`  in  `simmem_pkg::waddr_t`  write command; `burst_len` is the beat count.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command queue not full.
- `waddr_o`  out  `simmem_pkg::waddr_t`  write address request.
- `waddr_valid_o`  out  1  address valid.
- `waddr_ready_i`  in  1  address accepted.
- `wdata_valid_o`  out  1  data beat valid.
- `wdata_ready_i`  in  1  data beat accepted.
- `wdata_last_o`  out  1  last beat of the current burst.
- `wdata_beat_idx_o`  out  `MaxWBurstLenW`  beat index within the burst, starting at 0.
- `lead_cnt_o`  out  `$clog2(MaxDataLeadBeats+1)`  current data lead, for scoreboards.

## Operation
- Command queue: a circular buffer of `Depth` entries with one write pointer and two read pointers, `apt` (address) and `dpt` (data).
- Each entry holds the command, an `addr_done` flag, and a `beats_sent` count.
- Push: `cmd_valid_i && cmd_ready_o` writes the entry at the write pointer and clears its `addr_done` flag and `beats_sent` count.
- Address side: presents the entry at `apt` whenever `apt` ≠ write pointer.
  - On an address handshake, `apt` increments and the entry's `addr_done` flag is set.
- Data side: presents a beat of the entry at `dpt` when that entry is occupied and either of the following holds:
  - the entry's `addr_done` flag is set, or
  - `lead_q < MaxDataLeadBeats`.
- The data side does not depend on `apt`.
- `wdata_last_o` = (`beats_sent` == `burst_len - 1`). Its handshake advances `dpt` and resets the beat index.
- Lead accounting:
  - A beat handshake on an entry whose `addr_done` flag is clear increments `lead_q`.
  - An address handshake of an entry decrements `lead_q` by that entry's `beats_sent`.
  - Both updates apply in the same cycle if both handshakes occur.
  - A beat and the address of the same entry handshaking in the same cycle: the beat counts as following its address. `lead_q` does not increment for that beat.
- Free: the read pointer of the entry retires once `addr_done` is set and all beats are sent. The oldest entry frees first; occupancy = write pointer − min-progress pointer.
- `burst_len == 0`: the block issues the address only. No data beats are issued, and the entry is data-complete on push.
- Width rule: `lead_q` is unsigned and saturates by construction. It never exceeds `MaxDataLeadBeats` and never goes below 0.

## Timing
- Reset values: `cmd_ready_o`=1. All valids, `wdata_last_o`, `wdata_beat_idx_o`, `lead_cnt_o`, and the pointers are 0.
- Command-to-address latency is 1 cycle: a command accepted in cycle t can present `waddr_valid_o` in t+1. Command-to-first-beat latency is also 1 cycle.
- Valid/payload hold: once asserted, valid and payload stay stable until ready. Valid is never withdrawn.
- `cmd_ready_o` is computed from registered occupancy only. A cycle that frees an entry while the queue is full does not accept a command in that same cycle.
- Full throughput: one address per cycle and one beat per cycle, concurrently.
- Reset mid-burst: all outputs return to their reset values in the next cycle. In-flight commands are discarded.

## Configuration
- `SIMMEM_WREQ_ADDR_FIRST_EN` defined:
  - data lead is disabled, so a beat is presented only when its entry's `addr_done` flag is set;
  - `lead_cnt_o` is tied to 0;
  - the lead counter is removed.
- Undefined: data leads addresses up to `MaxDataLeadBeats`, as described in Operation.

## Structure
- `simmem_pkg` provides `waddr_t`, `MaxWBurstLen`, `MaxWBurstLenW`, and `AxLenWidth`, and gains a new constant `WReqQueueDepth`.
- Sub-module `simmem_wreq_queue` contains the circular buffer, the three pointers, the per-entry flags, full/empty tracking, and the free logic.
- The top level contains the handshake muxing and the lead counter.

## Test plan
- Single command `burst_len`=4 with both readies held high: address at t+1, then beats 0..3 in t+1..t+4, `wdata_last_o` on beat 3, and `lead_cnt_o` stays 0.
- `waddr_ready_i`=0 for 20 cycles with one command `burst_len`=16 queued (`MaxDataLeadBeats`=16): beats 0..15 are sent and `lead_cnt_o`=16. A second queued command's beats stall. Releasing the address drops `lead_cnt_o` to 0 in the next cycle.
- Address and beat 0 of the same entry handshake in the same cycle: `lead_cnt_o` stays 0.
- Fill 8 commands with `wdata_ready_i`=0: `cmd_ready_o` drops after the 8th command. Freeing one entry re-asserts `cmd_ready_o` on the following cycle, with no same-cycle push.
- Command `burst_len`=0: the address is issued and no data beat is issued. The following command's beat 0 starts with beat index 0.
- `rst_i` asserted mid-burst (beat 2 of 8): all valids are 0 on the next cycle, and `cmd_ready_o`=1.
